tmma_seq: RTL and testbench



---
 rtl/tmma_seq.sv | 246 ++++++++++++++++++++++++
 tb/tb_tmma_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmma_seq.sv
// -----------------------------------------------------------------------------
// tmma_seq -- sequencer for one tile matrix-multiply on a ROWS x COLS systolic
// array.
//
// A command carries a reduction length K and a precision. The sequencer reads
// K A-vectors and K B-vectors from the operand buffers (1-cycle read latency).
// It injects A lane r on left row r delayed by r cycles, and B lane c on top
// column c delayed by c cycles. This gives the diagonal wavefront the array
// expects. After the last beat plus the array drain time, it pulses done_o.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   cmd_valid_i / cmd_ready_o
//                            command handshake; ready only while idle
//   cmd_k_i, cmd_precision_i reduction length K and tile precision
//   busy_o, done_o           busy in every non-idle state; one-cycle done pulse
//   a_rd_* / b_rd_*          operand buffer read strobe, index and returned data
//   left_*                   per-row edge valid/cnt/type/precision/data
//   top_*                    per-column edge valid/cnt/data; storec tied low
// -----------------------------------------------------------------------------
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 8
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 4
`endif
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif

// -----------------------------------------------------------------------------
// tmma_skew_lane -- DEPTH-stage delay line for one edge lane.
// Valid, beat count and data move together.
//   clk, rst                    clock, async active-high reset
//   vld_in, cnt_in, dat_in      tagged beat from the read pipeline
//   vld_out, cnt_out, dat_out   same beat, DEPTH cycles later
// -----------------------------------------------------------------------------
module tmma_skew_lane #(
    parameter int DEPTH = 1,
    parameter int DW    = 8,
    parameter int CNTW  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vld_in,
    input  logic [CNTW-1:0] cnt_in,
    input  logic [DW-1:0]   dat_in,
    output logic            vld_out,
    output logic [CNTW-1:0] cnt_out,
    output logic [DW-1:0]   dat_out
);
    logic            vld_sr [DEPTH];
    logic [CNTW-1:0] cnt_sr [DEPTH];
    logic [DW-1:0]   dat_sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < DEPTH; s++) begin
                vld_sr[s] <= 1'b0;
                cnt_sr[s] <= '0;
                dat_sr[s] <= '0;
            end
        end else begin
            vld_sr[0] <= vld_in;
            cnt_sr[0] <= cnt_in;
            dat_sr[0] <= dat_in;
            for (int s = 1; s < DEPTH; s++) begin
                vld_sr[s] <= vld_sr[s-1];
                cnt_sr[s] <= cnt_sr[s-1];
                dat_sr[s] <= dat_sr[s-1];
            end
        end
    end

    assign vld_out = vld_sr[DEPTH-1];
    assign cnt_out = cnt_sr[DEPTH-1];
    assign dat_out = dat_sr[DEPTH-1];
endmodule

module tmma_seq #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int DW      = `PE_INPUT_DATA_WIDTH,
    parameter int CNTW    = `TMMA_CNT_WIDTH,
    parameter int PW      = `TMMA_PRECISION_WIDTH,
    parameter int MAC_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [CNTW-1:0]      cmd_k_i,
    input  logic [PW-1:0]        cmd_precision_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 a_rd_en_o,
    output logic [CNTW-1:0]      a_rd_idx_o,
    input  logic [ROWS*DW-1:0]   a_rd_data_i,
    output logic                 b_rd_en_o,
    output logic [CNTW-1:0]      b_rd_idx_o,
    input  logic [COLS*DW-1:0]   b_rd_data_i,
    output logic [ROWS-1:0]      left_data_valid_o,
    output logic [ROWS*CNTW-1:0] left_data_cnt_o,
    output logic [ROWS-1:0]      left_data_type_o,
    output logic [ROWS*PW-1:0]   left_precision_o,
    output logic [ROWS*DW-1:0]   left_data_o,
    output logic [COLS-1:0]      top_data_valid_o,
    output logic [COLS*CNTW-1:0] top_data_cnt_o,
    output logic [COLS*DW-1:0]   top_data_o,
    output logic [COLS-1:0]      top_storec_valid_o
);
    // Drain covers the longest skew path plus the MAC result latency.
    localparam int D   = ROWS + COLS - 1 + MAC_LAT;
    localparam int DRW = $clog2(D + 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] k_q, k_lat_q;
    logic [PW-1:0]   prec_q;
    logic [DRW-1:0]  drain_q;
    logic            rd_en;
    logic            accept;
    logic            vld_p1;
    logic [CNTW-1:0] cnt_p1;

    assign accept = (state_q == S_IDLE) && cmd_valid_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cmd_valid_i) state_d = (cmd_k_i == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (k_q == k_lat_q - CNTW'(1)) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == DRW'(D - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o = (state_q == S_IDLE);
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        rd_en       = (state_q == S_FETCH);
    end

    // Command latch, beat counter and drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_lat_q <= '0;
            prec_q  <= '0;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            if (accept) begin
                k_lat_q <= cmd_k_i;
                prec_q  <= cmd_precision_i;
            end
            k_q     <= (state_q == S_FETCH) ? k_q + CNTW'(1) : '0;
            drain_q <= (state_q == S_DRAIN) ? drain_q + DRW'(1) : '0;
        end
    end

    assign a_rd_en_o  = rd_en;
    assign b_rd_en_o  = rd_en;
    assign a_rd_idx_o = rd_en ? k_q : '0;
    assign b_rd_idx_o = rd_en ? k_q : '0;

    // ---- stage p1: tag the beat returning from the buffers with (valid, k)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            cnt_p1 <= '0;
        end else begin
            vld_p1 <= rd_en;
            cnt_p1 <= k_q;
        end
    end

    // ---- skew stages: row r / column c delay the tagged beat by r / c cycles
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic            row_vld;
        logic [CNTW-1:0] row_cnt;
        logic [DW-1:0]   row_dat;

        if (r == 0) begin : g_edge
            assign row_vld = vld_p1;
            assign row_cnt = cnt_p1;
            assign row_dat = a_rd_data_i[DW-1:0];
        end else begin : g_skew
            tmma_skew_lane #(.DEPTH(r), .DW(DW), .CNTW(CNTW)) u_lane (
                .clk     (clk),
                .rst     (rst),
                .vld_in  (vld_p1),
                .cnt_in  (cnt_p1),
                .dat_in  (a_rd_data_i[r*DW +: DW]),
                .vld_out (row_vld),
                .cnt_out (row_cnt),
                .dat_out (row_dat)
            );
        end

        assign left_data_valid_o[r]          = row_vld;
        assign left_data_cnt_o[r*CNTW +: CNTW] = row_vld ? row_cnt : '0;
        assign left_precision_o[r*PW +: PW]  = row_vld ? prec_q : '0;
        assign left_data_o[r*DW +: DW]       = row_vld ? row_dat : '0;
        assign left_data_type_o[r]           = `PE_DATA_TYPE_A;
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic            col_vld;
        logic [CNTW-1:0] col_cnt;
        logic [DW-1:0]   col_dat;

        if (c == 0) begin : g_edge
            assign col_vld = vld_p1;
            assign col_cnt = cnt_p1;
            assign col_dat = b_rd_data_i[DW-1:0];
        end else begin : g_skew
            tmma_skew_lane #(.DEPTH(c), .DW(DW), .CNTW(CNTW)) u_lane (
                .clk     (clk),
                .rst     (rst),
                .vld_in  (vld_p1),
                .cnt_in  (cnt_p1),
                .dat_in  (b_rd_data_i[c*DW +: DW]),
                .vld_out (col_vld),
                .cnt_out (col_cnt),
                .dat_out (col_dat)
            );
        end

        assign top_data_valid_o[c]          = col_vld;
        assign top_data_cnt_o[c*CNTW +: CNTW] = col_vld ? col_cnt : '0;
        assign top_data_o[c*DW +: DW]       = col_vld ? col_dat : '0;
    end

    assign top_storec_valid_o = '0;
endmodule

// File: tb/tb_tmma_seq.sv
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif

module tb_tmma_seq;
    localparam int ROWS = 4, COLS = 4, DW = 8, CNTW = 8, PW = 4, MAC_LAT = 1;
    localparam int D = ROWS + COLS - 1 + MAC_LAT;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cmd_valid_i = 1'b0;
    logic                 cmd_ready_o;
    logic [CNTW-1:0]      cmd_k_i = '0;
    logic [PW-1:0]        cmd_precision_i = '0;
    logic                 busy_o, done_o;
    logic                 a_rd_en_o, b_rd_en_o;
    logic [CNTW-1:0]      a_rd_idx_o, b_rd_idx_o;
    logic [ROWS*DW-1:0]   a_rd_data_i = '0;
    logic [COLS*DW-1:0]   b_rd_data_i = '0;
    logic [ROWS-1:0]      left_data_valid_o, left_data_type_o;
    logic [ROWS*CNTW-1:0] left_data_cnt_o;
    logic [ROWS*PW-1:0]   left_precision_o;
    logic [ROWS*DW-1:0]   left_data_o;
    logic [COLS-1:0]      top_data_valid_o, top_storec_valid_o;
    logic [COLS*CNTW-1:0] top_data_cnt_o;
    logic [COLS*DW-1:0]   top_data_o;

    tmma_seq #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .CNTW(CNTW), .PW(PW), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_k_i(cmd_k_i), .cmd_precision_i(cmd_precision_i),
        .busy_o(busy_o), .done_o(done_o),
        .a_rd_en_o(a_rd_en_o), .a_rd_idx_o(a_rd_idx_o), .a_rd_data_i(a_rd_data_i),
        .b_rd_en_o(b_rd_en_o), .b_rd_idx_o(b_rd_idx_o), .b_rd_data_i(b_rd_data_i),
        .left_data_valid_o(left_data_valid_o), .left_data_cnt_o(left_data_cnt_o),
        .left_data_type_o(left_data_type_o), .left_precision_o(left_precision_o),
        .left_data_o(left_data_o),
        .top_data_valid_o(top_data_valid_o), .top_data_cnt_o(top_data_cnt_o),
        .top_data_o(top_data_o), .top_storec_valid_o(top_storec_valid_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // Operand buffers: registered read, 1-cycle latency, junk when not read.
    logic [DW-1:0] amem [256][ROWS];
    logic [DW-1:0] bmem [256][COLS];

    always @(posedge clk) begin
        for (int r = 0; r < ROWS; r++)
            a_rd_data_i[r*DW +: DW] <= a_rd_en_o ? amem[a_rd_idx_o][r] : DW'($urandom);
        for (int c = 0; c < COLS; c++)
            b_rd_data_i[c*DW +: DW] <= b_rd_en_o ? bmem[b_rd_idx_o][c] : DW'($urandom);
    end

    task automatic fill_rand();
        for (int k = 0; k < 256; k++) begin
            for (int r = 0; r < ROWS; r++) amem[k][r] = DW'($urandom);
            for (int c = 0; c < COLS; c++) bmem[k][c] = DW'($urandom);
        end
    endtask

    task automatic fill_plan();
        for (int k = 0; k < 256; k++) begin
            for (int r = 0; r < ROWS; r++) amem[k][r] = DW'(16 * k + r);
            for (int c = 0; c < COLS; c++) bmem[k][c] = DW'(100 + 16 * k + c);
        end
    endtask

    // Reference model: cycle index of the period since the accept edge.
    int cyc = 0, t0 = 0, mk = 0, mprec = 0;
    bit m_act = 1'b0;

    function automatic int tile_end();
        return (mk == 0) ? 1 : mk + D + 1;
    endfunction

    function automatic bit m_busy();
        int n;
        n = cyc - t0;
        return m_act && (n >= 1) && (n <= tile_end());
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_act = 1'b0;
        else begin
            if (!m_busy() && cmd_valid_i) begin
                m_act = 1'b1;
                t0    = cyc;
                mk    = int'(cmd_k_i);
                mprec = int'(cmd_precision_i);
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        int n;
        bit busy_e, done_e, rd_e;
        logic [ROWS-1:0]      lv;
        logic [ROWS*CNTW-1:0] lc;
        logic [ROWS*PW-1:0]   lp;
        logic [ROWS*DW-1:0]   ld;
        logic [COLS-1:0]      tv;
        logic [COLS*CNTW-1:0] tc;
        logic [COLS*DW-1:0]   td;
        logic [CNTW-1:0]      idx_e;
        n = cyc - t0;
        busy_e = m_busy();
        done_e = m_act && (n == tile_end());
        rd_e   = m_act && (n >= 1) && (n <= mk);
        idx_e  = rd_e ? CNTW'(n - 1) : '0;
        lv = '0; lc = '0; lp = '0; ld = '0; tv = '0; tc = '0; td = '0;
        for (int r = 0; r < ROWS; r++)
            if (m_act && n >= 2 + r && n <= mk + 1 + r) begin
                lv[r] = 1'b1;
                lc[r*CNTW +: CNTW] = CNTW'(n - 2 - r);
                lp[r*PW +: PW]     = PW'(mprec);
                ld[r*DW +: DW]     = amem[n - 2 - r][r];
            end
        for (int c = 0; c < COLS; c++)
            if (m_act && n >= 2 + c && n <= mk + 1 + c) begin
                tv[c] = 1'b1;
                tc[c*CNTW +: CNTW] = CNTW'(n - 2 - c);
                td[c*DW +: DW]     = bmem[n - 2 - c][c];
            end
        chk("cmd_ready", 64'(cmd_ready_o), 64'(!busy_e));
        chk("busy", 64'(busy_o), 64'(busy_e));
        chk("done", 64'(done_o), 64'(done_e));
        chk("a_rd", 64'({a_rd_en_o, a_rd_idx_o}), 64'({rd_e, idx_e}));
        chk("b_rd", 64'({b_rd_en_o, b_rd_idx_o}), 64'({rd_e, idx_e}));
        chk("left_valid", 64'(left_data_valid_o), 64'(lv));
        chk("left_cnt", 64'(left_data_cnt_o), 64'(lc));
        chk("left_prec", 64'(left_precision_o), 64'(lp));
        chk("left_data", 64'(left_data_o), 64'(ld));
        chk("left_type", 64'(left_data_type_o), 64'({ROWS{`PE_DATA_TYPE_A}}));
        chk("top_valid", 64'(top_data_valid_o), 64'(tv));
        chk("top_cnt", 64'(top_data_cnt_o), 64'(tc));
        chk("top_data", 64'(top_data_o), 64'(td));
        chk("top_storec", 64'(top_storec_valid_o), 64'(0));
    end

    // Per-tile observations for the hand-computed expectations.
    int strobe_q[$], row2_n[$], row2_d[$], row2_c[$], row2_p[$], col3_n[$];
    int done_n, ready_after, last_r3_n, max_c0;

    task automatic issue(input int k, input int p);
        int n, guard;
        strobe_q.delete(); row2_n.delete(); row2_d.delete();
        row2_c.delete(); row2_p.delete(); col3_n.delete();
        done_n = -1; last_r3_n = -1; max_c0 = -1;
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_k_i = CNTW'(k); cmd_precision_i = PW'(p);
        guard = 0;
        while (!cmd_ready_o && guard < 100) begin @(negedge clk); guard++; end
        chk("accept_wait", 64'(guard < 100), 64'(1));
        @(negedge clk);
        cmd_valid_i = 1'b0; cmd_k_i = CNTW'($urandom);
        n = 1;
        while (n < 2000) begin
            if (a_rd_en_o) strobe_q.push_back(n);
            if (left_data_valid_o[2]) begin
                row2_n.push_back(n);
                row2_d.push_back(int'(left_data_o[2*DW +: DW]));
                row2_c.push_back(int'(left_data_cnt_o[2*CNTW +: CNTW]));
                row2_p.push_back(int'(left_precision_o[2*PW +: PW]));
            end
            if (top_data_valid_o[3]) col3_n.push_back(n);
            if (left_data_valid_o[3]) last_r3_n = n;
            if (top_data_valid_o[0] && int'(top_data_cnt_o[CNTW-1:0]) > max_c0)
                max_c0 = int'(top_data_cnt_o[CNTW-1:0]);
            if (done_o) begin done_n = n; break; end
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_n > 0), 64'(1));
        @(negedge clk);
        ready_after = int'(cmd_ready_o);
    endtask

    initial begin
        int guard, dcnt, kr;
        int dq[$];
        fill_rand();
        @(negedge clk);
        #1;
        chk("rst_ready", 64'(cmd_ready_o), 64'(1));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_left_valid", 64'(left_data_valid_o), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // K=3, precision 2, formula operands
        fill_plan();
        issue(3, 2);
        chk("k3_done_cycle", 64'(done_n), 64'(12));
        chk("k3_strobes", 64'(strobe_q.size()), 64'(3));
        chk("k3_row2_beats", 64'(row2_n.size()), 64'(3));
        if (row2_n.size() == 3) begin
            chk("k3_row2_cycles", 64'({row2_n[0][7:0], row2_n[1][7:0], row2_n[2][7:0]}), 64'({8'd4, 8'd5, 8'd6}));
            chk("k3_row2_data", 64'({row2_d[0][7:0], row2_d[1][7:0], row2_d[2][7:0]}), 64'({8'd2, 8'd18, 8'd34}));
            chk("k3_row2_cnt", 64'({row2_c[0][7:0], row2_c[1][7:0], row2_c[2][7:0]}), 64'({8'd0, 8'd1, 8'd2}));
            chk("k3_row2_prec", 64'({row2_p[0][7:0], row2_p[1][7:0], row2_p[2][7:0]}), 64'({8'd2, 8'd2, 8'd2}));
        end

        // K=1
        issue(1, 7);
        chk("k1_strobe_count", 64'(strobe_q.size()), 64'(1));
        if (strobe_q.size() == 1) chk("k1_strobe_cycle", 64'(strobe_q[0]), 64'(1));
        chk("k1_col3_count", 64'(col3_n.size()), 64'(1));
        if (col3_n.size() == 1) chk("k1_col3_cycle", 64'(col3_n[0]), 64'(5));
        chk("k1_done_cycle", 64'(done_n), 64'(10));
        chk("k1_ready_back", 64'(ready_after), 64'(1));

        // K=0
        issue(0, 3);
        chk("k0_done_cycle", 64'(done_n), 64'(1));
        chk("k0_no_strobe", 64'(strobe_q.size()), 64'(0));
        chk("k0_no_valid", 64'(row2_n.size() + col3_n.size() + (last_r3_n > 0)), 64'(0));
        chk("k0_ready_back", 64'(ready_after), 64'(1));

        // cmd_valid held high: tiles accepted every K+D+2 cycles
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_k_i = CNTW'(2); cmd_precision_i = PW'(5);
        guard = 0;
        while (!cmd_ready_o && guard < 100) begin @(negedge clk); guard++; end
        chk("held_accept_wait", 64'(guard < 100), 64'(1));
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 36) cmd_valid_i = 1'b0;
            if (done_o) dq.push_back(n);
        end
        chk("held_done_count", 64'(dq.size()), 64'(3));
        if (dq.size() == 3)
            chk("held_done_cycles", 64'({dq[0][7:0], dq[1][7:0], dq[2][7:0]}), 64'({8'd11, 8'd23, 8'd35}));

        // Reset in cycle 3 of a K=5 tile
        fill_rand();
        @(negedge clk);
        cmd_valid_i = 1'b1; cmd_k_i = CNTW'(5); cmd_precision_i = PW'(3);
        guard = 0;
        while (!cmd_ready_o && guard < 100) begin @(negedge clk); guard++; end
        @(negedge clk);
        cmd_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy_o), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_ready", 64'(cmd_ready_o), 64'(1));
        chk("arst_ctrl", 64'({busy_o, done_o, a_rd_en_o, b_rd_en_o, a_rd_idx_o, b_rd_idx_o}), 64'(0));
        chk("arst_left", 64'({left_data_valid_o, left_data_cnt_o, left_precision_o}), 64'(0));
        chk("arst_left_data", 64'(left_data_o), 64'(0));
        chk("arst_top", 64'({top_data_valid_o, top_data_cnt_o, top_storec_valid_o}), 64'(0));
        chk("arst_top_data", 64'(top_data_o), 64'(0));
        chk("arst_type", 64'(left_data_type_o), 64'({ROWS{`PE_DATA_TYPE_A}}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); dcnt += int'(done_o); end
        chk("no_done_after_rst", 64'(dcnt), 64'(0));
        issue(4, 1);
        chk("post_rst_done_cycle", 64'(done_n), 64'(13));

        // K=255: full count range, no wrap
        issue(255, 9);
        chk("k255_done_cycle", 64'(done_n), 64'(255 + D + 1));
        chk("k255_strobes", 64'(strobe_q.size()), 64'(255));
        chk("k255_max_cnt_col0", 64'(max_c0), 64'(254));
        chk("k255_last_row3", 64'(last_r3_n), 64'(259));

        // Randomized tiles
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 1) == 1) fill_rand();
            kr = int'($urandom_range(0, 30));
            issue(kr, int'($urandom_range(0, 15)));
            chk("rand_done_cycle", 64'(done_n), 64'((kr == 0) ? 1 : kr + D + 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
